// File: rtl/hs_pipe_pkg.sv
// -----------------------------------------------------------------------------
// hs_pipe_pkg
//
// Shared definitions for the clocked micropipeline (hs_pipeline_top):
//   - default data width and stage count
//   - state encodings for the upstream (input) and downstream (output)
//     four-phase handshake controllers
// -----------------------------------------------------------------------------
package hs_pipe_pkg;

  // Default word width carried through the pipeline.
  localparam int unsigned HS_DATA_W = 16;

  // Default number of register stages between capture and presentation.
  localparam int unsigned HS_DEPTH  = 3;

  // Upstream controller: waiting for a request, or holding the acknowledge
  // until the producer returns its request to zero.
  typedef enum logic {
    I_IDLE = 1'b0,
    I_ACK  = 1'b1
  } in_state_e;

  // Downstream controller: nothing offered, request raised, or waiting for
  // the consumer to return its acknowledge to zero.
  typedef enum logic [1:0] {
    O_IDLE = 2'd0,
    O_REQ  = 2'd1,
    O_WAIT = 2'd2
  } out_state_e;

endpackage : hs_pipe_pkg

// File: rtl/hs_pipe_stage.sv
// -----------------------------------------------------------------------------
// hs_pipe_stage
//
// One register stage of the micropipeline: a data register plus a full flag.
//
// Build option:
//   HS_PIPE_DATA_CLEAR_EN  when defined, the data register is cleared to zero
//                          on the edge the stage is emptied; otherwise the
//                          last word is retained. Full-flag timing is the
//                          same either way.
//
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset (empties stage, zeroes data)
//   load_i  in   capture data_i and mark the stage full at the next edge
//   free_i  in   mark the stage empty at the next edge
//   data_i  in   word to capture
//   full_o  out  stage currently holds a word
//   data_o  out  stored word
//
// The controller never asserts load_i and free_i together (load needs an
// empty stage, free needs a full one); load is given priority regardless.
// -----------------------------------------------------------------------------
module hs_pipe_stage
  import hs_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = HS_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              free_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              full_o,
  output logic [DATA_W-1:0] data_o
);

  logic              full_q, full_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (load_i) begin
      full_d = 1'b1;
      data_d = data_i;
    end else if (free_i) begin
      full_d = 1'b0;
`ifdef HS_PIPE_DATA_CLEAR_EN
      data_d = '0;
`else
      data_d = data_q;
`endif
    end
  end

  // Data is reset too: out_data must read zero while reset is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;

endmodule : hs_pipe_stage

// File: rtl/hs_pipeline_top.sv
// -----------------------------------------------------------------------------
// hs_pipeline_top
//
// Clocked emulation of an asynchronous request/acknowledge micropipeline.
// A word is captured from a four-phase upstream producer, rippled through
// DEPTH register stages, and offered to a four-phase downstream consumer.
//
// Build option:
//   HS_PIPE_DATA_CLEAR_EN  emptied stages clear their data to zero (see
//                          hs_pipe_stage); handshake timing is unchanged.
//
// Parameters:
//   DATA_W   word width
//   DEPTH    number of stages (>= 1)
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset; discards words in flight
//   in_req    in   upstream request (level, return-to-zero)
//   in_data   in   upstream word, stable while in_req=1 and out_ack=0
//   in_ack    in   downstream acknowledge of out_req (level, return-to-zero)
//   out_req   out  downstream request; out_data valid while high
//   out_ack   out  upstream acknowledge of in_req
//   out_data  out  word held in the last stage
// -----------------------------------------------------------------------------
module hs_pipeline_top
  import hs_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = HS_DATA_W,
  parameter int unsigned DEPTH  = HS_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_req,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_ack,
  output logic              out_req,
  output logic              out_ack,
  output logic [DATA_W-1:0] out_data
);

  localparam int unsigned LAST = DEPTH - 1;

  // ---------------------------------------------------------------------------
  // Stage array
  // ---------------------------------------------------------------------------
  logic [DEPTH-1:0]  stage_full;
  logic [DEPTH-1:0]  stage_load;
  logic [DEPTH-1:0]  stage_free;
  logic [DATA_W-1:0] stage_data [DEPTH];

  // Upstream capture and downstream pop strobes from the two controllers.
  logic capture;
  logic pop;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [DATA_W-1:0] load_data;

    // Stage 0 is fed by the input controller; later stages take a word from
    // their predecessor only when they were empty before the edge, so a
    // stage being vacated this edge stays empty for one cycle (a bubble).
    if (k == 0) begin : g_head
      assign stage_load[k] = capture;
      assign load_data     = in_data;
    end else begin : g_body
      assign stage_load[k] = stage_full[k-1] && !stage_full[k];
      assign load_data     = stage_data[k-1];
    end

    // The last stage is emptied only by the consumer's acknowledge; every
    // other stage empties exactly when its successor loads from it.
    if (k == LAST) begin : g_tail
      assign stage_free[k] = pop;
    end else begin : g_mid
      assign stage_free[k] = stage_full[k] && !stage_full[k+1];
    end

    hs_pipe_stage #(
      .DATA_W (DATA_W)
    ) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (stage_load[k]),
      .free_i (stage_free[k]),
      .data_i (load_data),
      .full_o (stage_full[k]),
      .data_o (stage_data[k])
    );
  end

  assign out_data = stage_data[LAST];

  // ---------------------------------------------------------------------------
  // Input controller: one capture per in_req high phase
  // ---------------------------------------------------------------------------
  in_state_e in_state_q, in_state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_state_q <= I_IDLE;
    end else begin
      in_state_q <= in_state_d;
    end
  end

  always_comb begin
    in_state_d = in_state_q;
    capture    = 1'b0;
    out_ack    = 1'b0;
    unique case (in_state_q)
      I_IDLE: begin
        // A full stage 0 is the only way the input is held off.
        if (in_req && !stage_full[0]) begin
          capture    = 1'b1;
          in_state_d = I_ACK;
        end
      end
      I_ACK: begin
        out_ack = 1'b1;
        if (!in_req) begin
          in_state_d = I_IDLE;
        end
      end
      default: begin
        in_state_d = I_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output controller: offer last stage, pop on ack, wait for ack to return
  // ---------------------------------------------------------------------------
  out_state_e out_state_q, out_state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_state_q <= O_IDLE;
    end else begin
      out_state_q <= out_state_d;
    end
  end

  always_comb begin
    out_state_d = out_state_q;
    pop         = 1'b0;
    out_req     = 1'b0;
    unique case (out_state_q)
      O_IDLE: begin
        // Also requires in_ack low, so a new request never overlaps the
        // previous acknowledge.
        if (stage_full[LAST] && !in_ack) begin
          out_state_d = O_REQ;
        end
      end
      O_REQ: begin
        out_req = 1'b1;
        if (in_ack) begin
          pop         = 1'b1;
          out_state_d = O_WAIT;
        end
      end
      O_WAIT: begin
        if (!in_ack) begin
          out_state_d = O_IDLE;
        end
      end
      default: begin
        out_state_d = O_IDLE;
      end
    endcase
  end

endmodule : hs_pipeline_top

// File: tb/tb_hs_pipeline_top.sv
// -----------------------------------------------------------------------------
// tb_hs_pipeline_top
//
// Directed and randomized stimulus for hs_pipeline_top (DATA_W=16, DEPTH=3).
// The reference model is a FIFO of words in capture order: every word
// acknowledged upstream is appended, every word offered downstream must
// match the head. Handshake timing is checked against the cycle counts of
// the behavioural description.
// -----------------------------------------------------------------------------
module tb_hs_pipeline_top;

  localparam int DW    = 16;
  localparam int DEPTH = 3;

  logic          clk;
  logic          rst_n;
  logic          in_req;
  logic [DW-1:0] in_data;
  logic          in_ack;
  logic          out_req;
  logic          out_ack;
  logic [DW-1:0] out_data;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: words accepted upstream and not yet delivered.
  logic [DW-1:0] exp_q [$];

  hs_pipeline_top #(
    .DATA_W (DW),
    .DEPTH  (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_req   (in_req),
    .in_data  (in_data),
    .in_ack   (in_ack),
    .out_req  (out_req),
    .out_ack  (out_ack),
    .out_data (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Passive monitor: counts out_req rising edges and any change of out_data
  // while out_req stays high.
  logic          mon_prev_req  = 1'b0;
  logic [DW-1:0] mon_prev_data = '0;
  int            req_rises     = 0;
  int            unstable      = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_prev_req <= 1'b0;
    end else begin
      if (out_req && !mon_prev_req) req_rises <= req_rises + 1;
      if (out_req && mon_prev_req && (out_data !== mon_prev_data)) unstable <= unstable + 1;
      mon_prev_req  <= out_req;
      mon_prev_data <= out_data;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Producer: one four-phase transfer, bounded wait for the acknowledge.
  task automatic send(input logic [DW-1:0] d);
    in_data = d;
    in_req  = 1'b1;
    for (int i = 0; i < 20 && !out_ack; i++) cyc();
    check("send_ack", out_ack, 1'b1);
    if (out_ack) exp_q.push_back(d);
    in_req = 1'b0;
    cyc();
    check("ack_fall", out_ack, 1'b0);
  endtask

  // Consumer: bounded wait for out_req, compare against model head, ack,
  // optionally hold in_ack high for 'hold' extra cycles.
  task automatic recv(input int hold);
    logic [DW-1:0] exp;
    int            hi;
    for (int i = 0; i < 20 && !out_req; i++) cyc();
    check("recv_req", out_req, 1'b1);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hDEAD;
    check("recv_data", out_data, exp);
    in_ack = 1'b1;
    cyc();
    check("req_fall", out_req, 1'b0);
    hi = 0;
    for (int i = 0; i < hold; i++) begin
      cyc();
      if (out_req) hi++;
    end
    if (hold > 0) check("req_held_low", hi, 0);
    in_ack = 1'b0;
    cyc();
  endtask

  initial begin
    int            rises0;
    int            bad;
    int            n;
    logic [DW-1:0] w;

    // ---- Reset with a pending request ----
    rst_n   = 1'b0;
    in_req  = 1'b1;
    in_data = 16'hFFFF;
    in_ack  = 1'b0;
    bad     = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (out_req !== 1'b0 || out_ack !== 1'b0 || out_data !== 16'h0) bad++;
    end
    check("reset_outputs", bad, 0);
    check("reset_out_data", out_data, 16'h0);
    in_req = 1'b0;
    cyc();
    rst_n = 1'b1;
    bad   = 0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      cyc();
      if (out_req !== 1'b0 || out_ack !== 1'b0) bad++;
    end
    check("no_capture_in_reset", bad, 0);

    // ---- Single transfer with exact timing ----
    in_data = 16'hA1A1;
    in_req  = 1'b1;
    cyc();                                   // E0: capture
    check("single_ack_rise", out_ack, 1'b1);
    exp_q.push_back(16'hA1A1);
    in_req = 1'b0;
    cyc();                                   // E1
    check("single_ack_fall", out_ack, 1'b0);
    check("single_req_e1", out_req, 1'b0);
    cyc();                                   // E2
    check("single_req_e2", out_req, 1'b0);
    cyc();                                   // E3
    check("single_req_e3", out_req, 1'b1);
    check("single_data", out_data, 16'hA1A1);
    in_ack = 1'b1;
    cyc();
    check("single_req_drop", out_req, 1'b0);
    void'(exp_q.pop_front());
    in_ack = 1'b0;
    cyc();

    // ---- Ordered sequence, one request per word ----
    rises0 = req_rises;
    send(16'hA1A1);
    send(16'hB2B2);
    send(16'hC3C3);
    recv(0);
    recv(0);
    recv(0);
    cyc();
    check("seq_one_req_per_word", req_rises - rises0, 3);

    // ---- Back-pressure: three accepted, fourth stalls ----
    send(16'h1111);
    send(16'h2222);
    send(16'h3333);
    repeat (4) cyc();
    in_data = 16'h4444;
    in_req  = 1'b1;
    bad     = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (out_ack) bad++;
    end
    check("bp_fourth_stalled", bad, 0);
    recv(0);                                 // frees last stage
    for (int i = 0; i < 20 && !out_ack; i++) cyc();
    check("bp_fourth_ack", out_ack, 1'b1);
    if (out_ack) exp_q.push_back(16'h4444);
    in_req = 1'b0;
    cyc();
    recv(0);
    recv(0);
    recv(0);
    check("bp_model_drained", exp_q.size(), 0);

    // ---- Four-phase rule: in_ack held high blocks the next request ----
    send(16'h5555);
    send(16'h6666);
    recv(6);
    recv(0);

    // ---- Randomized bursts against the FIFO model ----
    for (int r = 0; r < 12; r++) begin
      n = $urandom_range(1, DEPTH);
      for (int j = 0; j < n; j++) begin
        w = DW'($urandom);
        send(w);
      end
      for (int j = 0; j < n; j++) recv($urandom_range(0, 2));
    end
    check("rand_model_drained", exp_q.size(), 0);
    check("out_data_stable", unstable, 0);

    // ---- Mid-transfer reset ----
    send(16'h5A5A);
    for (int i = 0; i < 20 && !out_req; i++) cyc();
    check("mid_req_up", out_req, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_req", out_req, 1'b0);
    check("mid_rst_data", out_data, 16'h0);
    check("mid_rst_ack", out_ack, 1'b0);
    exp_q.delete();
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    check("post_rst_idle", out_req, 1'b0);
    send(16'h1234);
    recv(0);
    cyc();
    check("final_idle", out_req, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_hs_pipeline_top
